weight_stream_scheduler: RTL and testbench
==========================================

# weight_stream_scheduler

Sequences a 2-cycle-latency parameter ROM (the per-layer weight/bias memories) into a valid/ready stream for the dense and attention datapaths. A `start` pulse runs the configured number of full passes over the ROM. The block tracks in-flight reads and buffers them in a small credit-controlled FIFO, so `data_out_ready` backpressure never drops or duplicates a word. `done` pulses after the last word of the last pass is accepted.

## Interface
Parameters:
- `DATA_WIDTH`, 128, width of one ROM word (one parallel weight vector).
- `DEPTH`, 2304, number of ROM words per pass; must be ≥ 1.
- `ADDR_WIDTH`, `$clog2(DEPTH)+1`, ROM address width.
- `PASS_WIDTH`, 8, width of the pass count.
- `FIFO_DEPTH`, 4 (fixed), output buffer entries; must be ≥ ROM latency + 1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `num_passes`  in  PASS_WIDTH  passes to run; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `rom_addr`  out  ADDR_WIDTH  ROM read address.
- `rom_ce`  out  1  ROM clock enable; constant 1 so the ROM pipeline free-runs.
- `rom_q`  in  DATA_WIDTH  ROM data; word for the address issued in cycle c is presented in cycle c+2.
- `data_out`  out  DATA_WIDTH  FIFO head.
- `data_out_valid`  out  1  FIFO non-empty.
- `data_out_ready`  in  1  consumer accept.
- `data_out_last`  out  1  head word is address DEPTH-1, the last word of a pass.

## Operation
- **States:**
  - IDLE: on `start`, latch `num_passes`.
    - Non-zero count: go to RUN.
    - Zero count: pulse `done` next cycle and stay in IDLE. `busy` stays 0.
  - RUN: issue one read per cycle when credit allows. The address increments 0..DEPTH-1, then wraps to 0 and decrements the remaining-pass counter. Issuing address DEPTH-1 of the final pass moves the block to DRAIN.
  - DRAIN: no issues. When the in-flight count and FIFO count are both 0, pulse `done`, drop `busy`, and return to IDLE.
- **In-flight tracking:** a 2-stage shift register carries a valid bit and a last bit alongside each issued read. When stage 2 is valid, `rom_q` is written into the FIFO together with its last bit.
- **Credit rule:** issue in cycle c only if `fifo_count + inflight < FIFO_DEPTH`. Same-cycle pops are not credited. This guarantees no FIFO overflow, and with ready held high it still sustains 1 word/cycle.
- **Handshake:** a word is transferred when `data_out_valid && data_out_ready`. `data_out` and `data_out_last` hold stable while valid is high and ready is low.
- **Ignored starts:** `start` while `busy` is high, or in the same cycle as `done`, is ignored.
- **Counter widths:** `fifo_count` is 0..4 (3 bits) and `inflight` is 0..2. The address counter wraps exactly at DEPTH-1, never at 2^ADDR_WIDTH. With DEPTH=1, every issued word has the last bit set.
- **Reset:** `rst` in any state clears state, counters, the in-flight pipe and the FIFO. In-flight ROM data is discarded. No `done` is generated for an aborted run.

## Timing
- **Reset values:** `busy`=0, `done`=0, `rom_addr`=0, `data_out_valid`=0, `data_out_last`=0, `data_out`=0. `rom_ce`=1 always.
- `start` is sampled at the end of cycle 0. RUN begins in cycle 1, and `rom_addr`=0 is driven in cycle 1.
- `rom_q` carries word 0 in cycle 3, and it is written into the FIFO at the end of cycle 3. `data_out_valid` first rises in cycle 4, a start-to-first-valid latency of 4 cycles.
- With ready held high, N = DEPTH × num_passes words transfer in cycles 4..N+3. `done` is high in cycle N+4, and `busy` is low from cycle N+4.
- Backpressure: after ready falls, at most 2 more words arrive from the ROM. The FIFO fills to 4 and issue halts. When ready rises, throughput resumes with no bubble beyond the credit refill.
- `done` is never asserted in the same cycle as `data_out_valid` of the same run.

## Test plan
- **Single pass:** DEPTH=8, `num_passes`=1, ready=1. Words 0..7 appear in cycles 4..11, `data_out_last` is high only with word 7, and `done` pulses in cycle 12.
- **Multi-pass:** DEPTH=8, `num_passes`=3, ready=1. 24 words appear in the address sequence 0..7 repeated three times, `data_out_last` is high 3 times, and `done` pulses in cycle 28.
- **Backpressure:** ready toggles randomly (including 20 consecutive low cycles). All 8 words arrive once, in order, and are stable while stalled. The FIFO never exceeds 4 entries, and `rom_addr` holds while credit is exhausted.
- **Zero passes:** `start` with `num_passes`=0. `done` pulses in cycle 1, `busy` stays 0, and `data_out_valid` never rises.
- **Start while busy:** `start` pulses in cycle 5 of a run. It is ignored, and the run completes with the original pass count.
- **Mid-run reset:** `rst` is asserted in cycle 6 of a 3-pass run. All outputs are at reset values the next cycle, there is no `done`, and a fresh `start` restarts from address 0 with correct timing.

Source files
------------

// File: rtl/weight_stream_scheduler.sv
// Streams full passes over a 2-cycle-latency parameter ROM into a valid/ready interface,
// using credit-based issue so the 4-entry output FIFO can never overflow.
module weight_stream_scheduler #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 2304,
    parameter int ADDR_WIDTH = $clog2(DEPTH) + 1,
    parameter int PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last
);

    localparam int FIFO_DEPTH = 4;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PASS_WIDTH-1:0] passes_q, passes_d;
    logic                  done_q, done_d;
    logic                  s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic                  s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            fifo_count_q, fifo_count_d;

    logic [1:0]            inflight;
    logic                  credit_ok, issue, issue_last, push, pop;

    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign rom_addr       = addr_q;
    assign rom_ce         = 1'b1;
    assign data_out_valid = (fifo_count_q != 3'd0);
    assign data_out       = data_out_valid ? fifo_data[rd_ptr_q] : '0;
    assign data_out_last  = data_out_valid & fifo_last[rd_ptr_q];

    // Pops in the current cycle are deliberately not credited back to issue.
    always_comb begin
        inflight   = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
        credit_ok  = ({1'b0, fifo_count_q} + {2'b00, inflight}) < 4'(FIFO_DEPTH);
        issue      = (state_q == StRun) && credit_ok;
        issue_last = (addr_q == LAST_ADDR);
        push       = s2_valid_q;
        pop        = data_out_valid && data_out_ready;
    end

    always_comb begin
        fifo_count_d = fifo_count_q;
        unique case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 3'd1;
            2'b01:   fifo_count_d = fifo_count_q - 3'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        passes_d   = passes_q;
        done_d     = 1'b0;
        s1_valid_d = issue;
        s1_last_d  = issue && issue_last;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;

        unique case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is ignored.
                if (start && !done_q) begin
                    if (num_passes == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = StRun;
                        passes_d = num_passes;
                        addr_d   = '0;
                    end
                end
            end
            StRun: begin
                if (issue) begin
                    if (issue_last) begin
                        addr_d = '0;
                        if (passes_q == PASS_WIDTH'(1)) begin
                            state_d = StDrain;
                        end else begin
                            passes_d = passes_q - PASS_WIDTH'(1);
                        end
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StDrain: begin
                // Finish once the last word leaves, so done never overlaps valid.
                if (fifo_count_d == 3'd0 && !s1_valid_d && !s2_valid_d) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            passes_q     <= '0;
            done_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            passes_q     <= passes_d;
            done_q       <= done_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s2_valid_q   <= s2_valid_d;
            s2_last_q    <= s2_last_d;
            fifo_count_q <= fifo_count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
        end
    end

    // Storage needs no reset: the read side is gated by the reset-cleared count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= rom_q;
            fifo_last[wr_ptr_q] <= s2_last_q;
        end
    end

endmodule

// File: tb/tb_weight_stream_scheduler.sv
// Directed bench for weight_stream_scheduler with DEPTH=8 and a 2-cycle ROM model.
module tb_weight_stream_scheduler;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int PW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [PW-1:0] num_passes;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic          rom_ce;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          data_out_last;

    logic [AW-1:0] rom_a1;
    int            n_checks;
    int            n_fail;

    weight_stream_scheduler #(
        .DATA_WIDTH(DW),
        .DEPTH     (8),
        .ADDR_WIDTH(AW),
        .PASS_WIDTH(PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_passes    (num_passes),
        .busy          (busy),
        .done          (done),
        .rom_addr      (rom_addr),
        .rom_ce        (rom_ce),
        .rom_q         (rom_q),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .data_out_last (data_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int a);
        return 16'hC300 ^ 16'(a);
    endfunction

    // ROM model: address in cycle c, data in cycle c+2.
    always @(posedge clk) begin
        rom_a1 <= rom_addr;
        rom_q  <= word(int'(rom_a1));
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
        n_checks++; if (rom_addr !== 4'd0) begin n_fail++; $display("FAIL rst_addr got=%0d exp=0", rom_addr); end
        n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", data_out_valid); end
        n_checks++; if (data_out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got=%b exp=0", data_out_last); end
        n_checks++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=0000", data_out); end
        n_checks++; if (rom_ce !== 1'b1) begin n_fail++; $display("FAIL rst_ce got=%b exp=1", rom_ce); end
        rst = 1'b0;
    endtask

    task automatic test_single_pass();
        logic exp_v;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_v = (c >= 4 && c <= 11);
            n_checks++; if (data_out_valid !== exp_v) begin n_fail++; $display("FAIL sp_valid c=%0d got=%b exp=%b", c, data_out_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (data_out !== word(c - 4)) begin n_fail++; $display("FAIL sp_data c=%0d got=%h exp=%h", c, data_out, word(c - 4)); end
                n_checks++; if (data_out_last !== (c == 11)) begin n_fail++; $display("FAIL sp_last c=%0d got=%b", c, data_out_last); end
            end
            n_checks++; if (done !== (c == 12)) begin n_fail++; $display("FAIL sp_done c=%0d got=%b", c, done); end
            n_checks++; if (busy !== (c >= 1 && c <= 11)) begin n_fail++; $display("FAIL sp_busy c=%0d got=%b", c, busy); end
            start = (c == 0);
            num_passes = 8'd1;
        end
    endtask

    task automatic test_multi_pass();
        logic exp_v;
        int   n_last;
        n_last = 0;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            exp_v = (c >= 4 && c <= 27);
            n_checks++; if (data_out_valid !== exp_v) begin n_fail++; $display("FAIL mp_valid c=%0d got=%b exp=%b", c, data_out_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (data_out !== word((c - 4) % 8)) begin n_fail++; $display("FAIL mp_data c=%0d got=%h exp=%h", c, data_out, word((c - 4) % 8)); end
                n_checks++; if (data_out_last !== ((c - 4) % 8 == 7)) begin n_fail++; $display("FAIL mp_last c=%0d got=%b", c, data_out_last); end
            end
            if (data_out_valid === 1'b1 && data_out_last === 1'b1) n_last++;
            n_checks++; if (done !== (c == 28)) begin n_fail++; $display("FAIL mp_done c=%0d got=%b", c, done); end
            n_checks++; if (busy !== (c >= 1 && c <= 27)) begin n_fail++; $display("FAIL mp_busy c=%0d got=%b", c, busy); end
            start = (c == 0);
            num_passes = 8'd3;
        end
        n_checks++; if (n_last != 3) begin n_fail++; $display("FAIL mp_last_count got=%0d exp=3", n_last); end
    endtask

    task automatic test_backpressure();
        int   exp_idx;
        int   n_done;
        logic rdy;
        exp_idx = 0;
        n_done  = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            rdy = (c <= 4) ? 1'b1 : (c <= 24) ? 1'b0 : (c % 3 != 0);
            data_out_ready = rdy;
            start = (c == 0);
            num_passes = 8'd1;
            if (c == 12 || c == 24) begin
                n_checks++; if (rom_addr !== 4'd5) begin n_fail++; $display("FAIL bp_addr_hold c=%0d got=%0d exp=5", c, rom_addr); end
            end
            if (data_out_valid === 1'b1) begin
                n_checks++; if (exp_idx > 7 || data_out !== word(exp_idx)) begin n_fail++; $display("FAIL bp_data c=%0d got=%h idx=%0d exp=%h", c, data_out, exp_idx, word(exp_idx)); end
                n_checks++; if (data_out_last !== (exp_idx == 7)) begin n_fail++; $display("FAIL bp_last c=%0d got=%b idx=%0d", c, data_out_last, exp_idx); end
                if (rdy) exp_idx++;
            end
            n_checks++; if (done === 1'b1 && data_out_valid === 1'b1) begin n_fail++; $display("FAIL bp_done_overlap c=%0d done=%b valid=%b", c, done, data_out_valid); end
            if (done === 1'b1) n_done++;
        end
        data_out_ready = 1'b1;
        n_checks++; if (exp_idx != 8) begin n_fail++; $display("FAIL bp_word_count got=%0d exp=8", exp_idx); end
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL bp_done_count got=%0d exp=1", n_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_zero_passes();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++; if (done !== (c == 1)) begin n_fail++; $display("FAIL zp_done c=%0d got=%b", c, done); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zp_busy c=%0d got=%b exp=0", c, busy); end
            n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL zp_valid c=%0d got=%b exp=0", c, data_out_valid); end
            // Second start lands on the done cycle and must be ignored.
            start = (c == 0 || c == 1);
            num_passes = (c == 0) ? 8'd0 : 8'd1;
        end
    endtask

    task automatic test_start_while_busy();
        logic exp_v;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            exp_v = (c >= 4 && c <= 11);
            n_checks++; if (data_out_valid !== exp_v) begin n_fail++; $display("FAIL swb_valid c=%0d got=%b exp=%b", c, data_out_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (data_out !== word(c - 4)) begin n_fail++; $display("FAIL swb_data c=%0d got=%h exp=%h", c, data_out, word(c - 4)); end
            end
            n_checks++; if (done !== (c == 12)) begin n_fail++; $display("FAIL swb_done c=%0d got=%b", c, done); end
            n_checks++; if (busy !== (c >= 1 && c <= 11)) begin n_fail++; $display("FAIL swb_busy c=%0d got=%b", c, busy); end
            start = (c == 0 || c == 5);
            num_passes = (c == 0) ? 8'd1 : 8'd3;
        end
    endtask

    task automatic test_mid_run_reset();
        logic exp_v;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 7) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrr_busy got=%b exp=0", busy); end
                n_checks++; if (rom_addr !== 4'd0) begin n_fail++; $display("FAIL mrr_addr got=%0d exp=0", rom_addr); end
                n_checks++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL mrr_data got=%h exp=0000", data_out); end
                n_checks++; if (data_out_last !== 1'b0) begin n_fail++; $display("FAIL mrr_last got=%b exp=0", data_out_last); end
            end
            if (c >= 7) begin
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mrr_no_done c=%0d got=%b exp=0", c, done); end
                n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL mrr_valid c=%0d got=%b exp=0", c, data_out_valid); end
            end
            start = (c == 0);
            num_passes = 8'd3;
            rst = (c == 6);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_v = (c >= 4 && c <= 11);
            n_checks++; if (data_out_valid !== exp_v) begin n_fail++; $display("FAIL mrr2_valid c=%0d got=%b exp=%b", c, data_out_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (data_out !== word(c - 4)) begin n_fail++; $display("FAIL mrr2_data c=%0d got=%h exp=%h", c, data_out, word(c - 4)); end
            end
            if (c == 1) begin
                n_checks++; if (rom_addr !== 4'd0) begin n_fail++; $display("FAIL mrr2_addr got=%0d exp=0", rom_addr); end
            end
            n_checks++; if (done !== (c == 12)) begin n_fail++; $display("FAIL mrr2_done c=%0d got=%b", c, done); end
            start = (c == 0);
            num_passes = 8'd1;
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        start          = 1'b0;
        num_passes     = 8'd0;
        data_out_ready = 1'b1;
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_backpressure();
        test_zero_passes();
        test_start_while_busy();
        test_mid_run_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
